// File: rtl/delay_pkg.sv
// -----------------------------------------------------------------------------
// delay_pkg
// Shared helpers for the programmable delay line.
//   depth_w(max_depth)          : width of a depth selector able to encode
//                                 0..max_depth inclusive.
//   clamp_depth(sel, max_depth) : maps a requested depth onto the legal range
//                                 1..max_depth (0 -> 1, above max -> max).
// The per-stage {vld, data} record depends on WIDTH and is therefore declared
// inside the module that owns the WIDTH parameter.
// -----------------------------------------------------------------------------
package delay_pkg;

    localparam int DEFAULT_WIDTH     = 8;
    localparam int DEFAULT_MAX_DEPTH = 16;

    function automatic int depth_w(input int max_depth);
        return $clog2(max_depth + 1);
    endfunction

    function automatic int clamp_depth(input int sel, input int max_depth);
        if (sel < 1) begin
            return 1;
        end
        if (sel > max_depth) begin
            return max_depth;
        end
        return sel;
    endfunction

endpackage

// File: rtl/delay_stage.sv
// -----------------------------------------------------------------------------
// delay_stage
// One W-bit register of the delay chain.
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset, loads RST_VAL
//   en      : capture d when high, hold when low
//   flush   : synchronous load of RST_VAL, takes priority over en
//   d       : next-stage input
//   q       : registered stage contents
// -----------------------------------------------------------------------------
module delay_stage #(
    parameter int           W       = 9,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         flush,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= RST_VAL;
        end else if (flush) begin
            q_reg <= RST_VAL;
        end else if (en) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/prog_delay_line.sv
// -----------------------------------------------------------------------------
// prog_delay_line
// Runtime-programmable delay line for a data word and its valid bit.
// MAX_DEPTH enable-gated stages form a shift chain; the output is tapped at the
// stage chosen by depth_sel (clamped to 1..MAX_DEPTH).
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   en        : advance the chain; all stages hold when low
//   flush     : synchronous clear of every stage and of cfg_err (beats en)
//   depth_sel : requested delay in stages, legal 1..MAX_DEPTH
//   in_valid  : qualifier for in_data
//   in_data   : data to delay
//   out_valid : valid bit of the tapped stage
//   out_data  : data of the tapped stage
//   cfg_err   : sticky, set on any edge that sees an out-of-range depth_sel
// -----------------------------------------------------------------------------
module prog_delay_line
    import delay_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter int               MAX_DEPTH = DEFAULT_MAX_DEPTH,
    parameter logic [WIDTH-1:0] RST_VAL   = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           en,
    input  logic                           flush,
    input  logic [depth_w(MAX_DEPTH)-1:0]  depth_sel,
    input  logic                           in_valid,
    input  logic [WIDTH-1:0]               in_data,
    output logic                           out_valid,
    output logic [WIDTH-1:0]               out_data,
    output logic                           cfg_err
);

    localparam int DW = depth_w(MAX_DEPTH);

    typedef struct packed {
        logic             vld;
        logic [WIDTH-1:0] data;
    } stage_t;

    localparam stage_t STAGE_RST = '{vld: 1'b0, data: RST_VAL};

    stage_t [MAX_DEPTH-1:0] stage_d;
    stage_t [MAX_DEPTH-1:0] stage_q;

    // Shift chain: stage 0 takes the input, every other stage its predecessor.
    // Bubbles (in_valid=0) advance like any other entry.
    for (genvar gi = 0; gi < MAX_DEPTH; gi++) begin : g_stage
        if (gi == 0) begin : g_head
            assign stage_d[gi] = '{vld: in_valid, data: in_data};
        end else begin : g_body
            assign stage_d[gi] = stage_q[gi-1];
        end

        delay_stage #(
            .W       (WIDTH + 1),
            .RST_VAL (STAGE_RST)
        ) u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (en),
            .flush (flush),
            .d     (stage_d[gi]),
            .q     (stage_q[gi])
        );
    end

    // Tap selection is purely combinational from depth_sel, so a depth change
    // is visible immediately and never disturbs the stored entries.
    logic [DW-1:0] tap_idx;
    logic          range_err;
    stage_t        tap;

    always_comb begin
        tap_idx   = DW'(clamp_depth(int'(depth_sel), MAX_DEPTH) - 1);
        range_err = (depth_sel == '0) || (depth_sel > DW'(MAX_DEPTH));
        tap       = stage_q[0];
        for (int i = 1; i < MAX_DEPTH; i++) begin
            if (tap_idx == DW'(i)) begin
                tap = stage_q[i];
            end
        end
    end

    assign out_valid = tap.vld;
    assign out_data  = tap.data;

    // Sticky configuration error; a flush on the same edge clears it.
    logic cfg_err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err_reg <= 1'b0;
        end else if (flush) begin
            cfg_err_reg <= 1'b0;
        end else if (range_err) begin
            cfg_err_reg <= 1'b1;
        end
    end

    assign cfg_err = cfg_err_reg;

endmodule

// File: tb/tb_prog_delay_line.sv
// -----------------------------------------------------------------------------
// tb_prog_delay_line
// Directed bench for prog_delay_line (WIDTH=8, MAX_DEPTH=16, RST_VAL=0).
// Per-cycle vectors hold inputs applied just after a rising edge and the
// outputs expected just after the following rising edge. Reset, depth-switch
// and out-of-range sweeps are written out by hand after the table.
// -----------------------------------------------------------------------------
module tb_prog_delay_line;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       flush;
    logic [4:0] depth_sel;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_valid;
    logic [7:0] out_data;
    logic       cfg_err;

    int errors = 0;
    int checks = 0;

    prog_delay_line #(
        .WIDTH     (8),
        .MAX_DEPTH (16),
        .RST_VAL   (8'h00)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .flush     (flush),
        .depth_sel (depth_sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .cfg_err   (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       flush;
        logic       vin;
        logic [7:0] din;
        logic [4:0] dsel;
        logic       ev;
        logic [7:0] ed;
        logic       eerr;
    } vec_t;

    vec_t vecs [25];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_out(input string name, input logic ev, input logic [7:0] ed,
                             input logic eerr);
        check({name, ".valid"}, 32'(out_valid), 32'(ev));
        check({name, ".data"},  32'(out_data),  32'(ed));
        check({name, ".err"},   32'(cfg_err),   32'(eerr));
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // en flush vin din dsel | valid data err
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 8'h11, 5'd2,  1'b0, 8'h00, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 8'h22, 5'd2,  1'b1, 8'h11, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 8'h33, 5'd2,  1'b1, 8'h22, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 8'h00, 5'd2,  1'b1, 8'h33, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 8'h00, 5'd2,  1'b0, 8'h00, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 8'h00, 5'd2,  1'b0, 8'h00, 1'b0};
        // stall: A5 presented, then three cycles with en low
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 8'hA5, 5'd4,  1'b0, 8'h00, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 8'h00, 5'd4,  1'b0, 8'h00, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 8'hEE, 5'd4,  1'b0, 8'h00, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 8'hEE, 5'd4,  1'b0, 8'h00, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 8'hEE, 5'd4,  1'b0, 8'h00, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 8'h00, 5'd4,  1'b0, 8'h00, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 8'h00, 5'd4,  1'b1, 8'hA5, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 8'h00, 5'd4,  1'b0, 8'h00, 1'b0};
        // flush vs en with three entries in flight
        vecs[14] = '{1'b1, 1'b0, 1'b1, 8'h01, 5'd4,  1'b0, 8'h00, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 1'b1, 8'h02, 5'd4,  1'b0, 8'h00, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 1'b1, 8'h03, 5'd3,  1'b1, 8'h01, 1'b0};
        vecs[17] = '{1'b1, 1'b1, 1'b1, 8'h5A, 5'd3,  1'b0, 8'h00, 1'b0};
        vecs[18] = '{1'b1, 1'b0, 1'b0, 8'h00, 5'd1,  1'b0, 8'h00, 1'b0};
        vecs[19] = '{1'b0, 1'b0, 1'b0, 8'h00, 5'd2,  1'b0, 8'h00, 1'b0};
        // out of range: 0 acts as depth 1, 17 as depth 16, error is sticky
        vecs[20] = '{1'b1, 1'b0, 1'b1, 8'h77, 5'd0,  1'b1, 8'h77, 1'b1};
        vecs[21] = '{1'b1, 1'b0, 1'b1, 8'h78, 5'd17, 1'b0, 8'h00, 1'b1};
        vecs[22] = '{1'b1, 1'b0, 1'b0, 8'h00, 5'd2,  1'b1, 8'h78, 1'b1};
        vecs[23] = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd0,  1'b0, 8'h00, 1'b0};
        vecs[24] = '{1'b1, 1'b0, 1'b0, 8'h00, 5'd3,  1'b0, 8'h00, 1'b0};

        // Power-on reset, checked before any clock edge.
        rst_n     = 1'b0;
        en        = 1'b0;
        flush     = 1'b0;
        depth_sel = 5'd2;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        #1;
        check_out("por", 1'b0, 8'h00, 1'b0);
        $display("txn por: valid=%0b data=%02h err=%0b", out_valid, out_data, cfg_err);
        step();
        step();
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 25; i++) begin
            en        = vecs[i].en;
            flush     = vecs[i].flush;
            in_valid  = vecs[i].vin;
            in_data   = vecs[i].din;
            depth_sel = vecs[i].dsel;
            step();
            check_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].eerr);
            $display("txn vec%0d: en=%0b flush=%0b in=%0b/%02h dsel=%0d -> valid=%0b data=%02h err=%0b",
                     i, en, flush, in_valid, in_data, depth_sel, out_valid, out_data, cfg_err);
        end

        // Depth switch: ramp 1..16 at depth 16, then retap without clocking.
        en = 1'b0; flush = 1'b1; in_valid = 1'b0; in_data = 8'h00; depth_sel = 5'd16;
        step();
        flush = 1'b0;
        en    = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            step();
        end
        en = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        check_out("ramp_d16", 1'b1, 8'h01, 1'b0);
        $display("txn ramp d16: valid=%0b data=%02h", out_valid, out_data);
        depth_sel = 5'd4;  #1;
        check_out("ramp_d4", 1'b1, 8'h0D, 1'b0);
        $display("txn ramp d4: valid=%0b data=%02h", out_valid, out_data);
        depth_sel = 5'd16; #1;
        check_out("ramp_back16", 1'b1, 8'h01, 1'b0);
        $display("txn ramp back d16: valid=%0b data=%02h", out_valid, out_data);
        depth_sel = 5'd1;  #1;
        check_out("ramp_d1", 1'b1, 8'h10, 1'b0);
        $display("txn ramp d1: valid=%0b data=%02h", out_valid, out_data);
        depth_sel = 5'd31; #1;
        check_out("ramp_d31", 1'b1, 8'h01, 1'b0);
        $display("txn ramp d31: valid=%0b data=%02h", out_valid, out_data);
        // A held edge with an illegal depth latches the error, keeps contents.
        step();
        check_out("hold_d31", 1'b1, 8'h01, 1'b1);
        $display("txn hold d31: valid=%0b data=%02h err=%0b", out_valid, out_data, cfg_err);

        // Reset mid-stream, asserted between edges: outputs clear at once.
        depth_sel = 5'd16;
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_rst", 1'b0, 8'h00, 1'b0);
        $display("txn async reset: valid=%0b data=%02h err=%0b", out_valid, out_data, cfg_err);
        for (int d = 1; d <= 16; d++) begin
            depth_sel = 5'(d);
            #1;
            check($sformatf("rst_stage%0d.valid", d), 32'(out_valid), 32'd0);
            check($sformatf("rst_stage%0d.data", d),  32'(out_data),  32'd0);
        end
        $display("txn reset sweep: all 16 stages examined");
        step();
        rst_n = 1'b1;
        en = 1'b1; in_valid = 1'b1; in_data = 8'h3C; depth_sel = 5'd1;
        step();
        check_out("post_rst", 1'b1, 8'h3C, 1'b0);
        $display("txn post reset: valid=%0b data=%02h err=%0b", out_valid, out_data, cfg_err);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
